overlay_scope_ctrl: RTL and testbench
=====================================

OVERLAY_SCOPE_CTRL -- requirements
Module: overlay_scope_ctrl

Interface
REQ-001 SHALL have ports: clk_vid  in  1  video pixel clock, the only clock.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: din  in  8  audio sample, unsigned, midscale 8'h80.
REQ-004 SHALL have ports: sample  in  1  one-cycle strobe in clk_vid; din valid on that cycle.
REQ-005 SHALL have ports: status  in  4  [2:0] mode (0 = overlay off), [3] freeze history.
REQ-006 SHALL have ports: hsync, vsync  in  1 each  active-low syncs, synchronous to clk_vid.
REQ-007 SHALL have ports: en  in  1  overlay enable.
REQ-008 SHALL have ports: color  out  8  overlay pixel, 8'h80 when lit, else 8'h00.
REQ-009 SHALL have parameters: HIST_DEPTH, default 32, number of history columns (power of two).
REQ-010 SHALL have parameters: COL_BASE, default 704, first hcount of column 0; COL_SHIFT, default 6, log2 clocks per column; LINE_BASE, default 480, bar baseline line.

Function
REQ-011 SHALL sample all inputs on rising clk_vid only; no logic clocked by hsync/vsync.
REQ-012 SHALL compute mag = |din - 128| clamped to 127 (7 bits); din=8'h00 -> 127, 8'h80 -> 0, 8'hFF -> 127.
REQ-013 SHALL hold a 7-bit frame peak: on sample, peak <= max(peak, mag).
REQ-014 SHALL detect frame start as vsync 1->0 (registered edge detect, one-cycle pulse).
REQ-015 SHALL on frame start, with status[3]=0: write peak into history[wr_ptr], wr_ptr <= wr_ptr+1 mod HIST_DEPTH; with status[3]=1: no write, wr_ptr held.
REQ-016 SHALL on frame start clear peak to 0; sample on the same cycle loads peak <= mag (new frame), old peak is what commits.
REQ-017 SHALL run hcount (13 bits): reset to 0 while hsync=0, else +1, saturating at 8191.
REQ-018 SHALL run vcount (10 bits): +1 on hsync 0->1, saturating at 1023; cleared to 0 on any cycle with vsync=0 (clear wins over increment).
REQ-019 SHALL derive column c = (hcount - COL_BASE) >> COL_SHIFT; column valid only when hcount >= COL_BASE and c < HIST_DEPTH.
REQ-020 SHALL display newest-left: column c reads history[(wr_ptr - 1 - c) mod HIST_DEPTH].
REQ-021 SHALL set lit = en & (status[2:0] != 0) & column valid & (vcount > LINE_BASE - height), height = history entry (0..127); height 0 never lit.
REQ-022 SHALL register color: color reflects hcount/vcount of the previous cycle (latency 1 clk).
REQ-023 SHALL treat a history write and a read of the same entry on one cycle as read-old-data.
REQ-024 SHALL run state machine FILL -> RUN: FILL after reset, entries not yet written read as 0; RUN once HIST_DEPTH commits done; reset returns to FILL.

Reset
REQ-025 SHALL on reset_n=0 asynchronously clear: color, peak, wr_ptr, hcount, vcount, all history entries, edge-detect registers, state=FILL.
REQ-026 SHALL, on reset mid-frame, lose the partial peak; first frame start after release commits only samples seen after release.

Structure
REQ-027 SHALL place HIST_DEPTH default, COL_BASE, COL_SHIFT, LINE_BASE, COLOR_ON (8'h80) and the state enum in shared package overlay_pkg.
REQ-028 SHALL use one sub-module overlay_hist_ram: HIST_DEPTH x 7 register file, 1 write, 1 combinational read, async clear on reset_n.

Verification
REQ-029 SHALL test: samples 8'h90, 8'h20, 8'h70 in one frame, then vsync fall -> history[0]=96 (0x60), peak=0, wr_ptr=1.
REQ-030 SHALL test: sample coincident with vsync fall, din=8'hFF, prior peak 5 -> committed 5, new peak 127.
REQ-031 SHALL test: status[3]=1 across 3 frames -> wr_ptr unchanged, history unchanged; peak still clears each frame.
REQ-032 SHALL test: history[wr_ptr-1]=40, hcount=704 for column 0 -> color=8'h80 for vcount 441..1023 and 8'h00 at vcount 440, one clk after hcount.
REQ-033 SHALL test: 33 frames committed -> wr_ptr wraps to 1, state RUN, column 31 shows frame 2's peak.
REQ-034 SHALL test: reset_n pulsed mid-line with color=8'h80 -> color 8'h00 immediately (async), all 32 columns dark after release.

Source files
------------

// File: rtl/overlay_pkg.sv
// overlay_pkg: shared constants, state enum and sample magnitude helper for the audio scope overlay.
package overlay_pkg;
    localparam int HIST_DEPTH = 32;
    localparam int COL_BASE   = 704;
    localparam int COL_SHIFT  = 6;
    localparam int LINE_BASE  = 480;
    localparam logic [7:0] COLOR_ON = 8'h80;

    typedef enum logic {FILL, RUN} state_t;

    // |d - 128| with the single out-of-range case (d = 0 -> 128) clamped to 127
    function automatic logic [6:0] sample_mag(input logic [7:0] d);
        return d[7] ? d[6:0] : (d == 8'd0) ? 7'd127 : 7'(8'd128 - d);
    endfunction
endpackage

// File: rtl/overlay_hist_ram.sv
// overlay_hist_ram: peak history register file, one write port, one combinational read port.
module overlay_hist_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data
);
    logic [6:0] mem [DEPTH];

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // read sees the pre-write contents on a same-cycle write
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/overlay_scope_ctrl.sv
// overlay_scope_ctrl: per-frame audio peak history drawn as bars on the video raster.
module overlay_scope_ctrl
    import overlay_pkg::*;
#(
    parameter int HIST_DEPTH = overlay_pkg::HIST_DEPTH,
    parameter int COL_BASE   = overlay_pkg::COL_BASE,
    parameter int COL_SHIFT  = overlay_pkg::COL_SHIFT,
    parameter int LINE_BASE  = overlay_pkg::LINE_BASE
) (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       sample,
    input  logic [3:0] status,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       en,
    output logic [7:0] color
);
    localparam int AW = $clog2(HIST_DEPTH);

    state_t        state, state_nx;
    logic          vs_q, hs_q;
    logic [6:0]    peak, mag, height_raw, height;
    logic [AW-1:0] wr_ptr, rd_idx;
    logic [12:0]   hcount, col_off, col;
    logic [9:0]    vcount;
    logic          frame_start, commit, hs_rise, col_ok, lit;

    assign mag         = sample_mag(din);
    assign frame_start = vs_q & ~vsync;
    assign commit      = frame_start & ~status[3];
    assign hs_rise     = ~hs_q & hsync;

    assign col_off = hcount - 13'(COL_BASE);
    assign col     = col_off >> COL_SHIFT;
    assign col_ok  = (hcount >= 13'(COL_BASE)) && (col < 13'(HIST_DEPTH));
    assign rd_idx  = wr_ptr - AW'(1) - col[AW-1:0];

    overlay_hist_ram #(.DEPTH(HIST_DEPTH), .AW(AW)) u_ram (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .wr_en   (commit),
        .wr_addr (wr_ptr),
        .wr_data (peak),
        .rd_addr (rd_idx),
        .rd_data (height_raw)
    );

    // while filling, slots at or beyond wr_ptr have never been committed
    assign height = (state == FILL && rd_idx >= wr_ptr) ? 7'd0 : height_raw;
    // vcount > LINE_BASE - height, rearranged to avoid an underflowing subtraction
    assign lit = en && (status[2:0] != 3'd0) && col_ok && (height != 7'd0) &&
                 (({1'b0, vcount} + {4'd0, height}) > 11'(LINE_BASE));

    always_comb begin
        state_nx = state;
        state_nx = (state == FILL && commit && &wr_ptr) ? RUN : state;
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FILL;
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
            peak   <= '0;
            wr_ptr <= '0;
            hcount <= '0;
            vcount <= '0;
            color  <= '0;
        end else begin
            state  <= state_nx;
            vs_q   <= vsync;
            hs_q   <= hsync;
            peak   <= frame_start ? (sample ? mag : 7'd0) :
                      (sample && mag > peak) ? mag : peak;
            wr_ptr <= commit ? wr_ptr + AW'(1) : wr_ptr;
            hcount <= !hsync ? 13'd0 : (&hcount ? hcount : hcount + 13'd1);
            vcount <= !vsync ? 10'd0 : (hs_rise && !(&vcount)) ? vcount + 10'd1 : vcount;
            color  <= lit ? COLOR_ON : 8'h00;
        end
    end
endmodule

// File: tb/tb_overlay_scope_ctrl.sv
// tb_overlay_scope_ctrl: directed scenarios for peak capture, history commit, freeze, display and reset.
module tb_overlay_scope_ctrl;
    import overlay_pkg::*;

    logic       clk_vid = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] din     = 8'h80;
    logic       sample  = 1'b0;
    logic [3:0] status  = 4'b0001;
    logic       hsync   = 1'b1;
    logic       vsync   = 1'b1;
    logic       en      = 1'b1;
    logic [7:0] color;
    int total = 0;
    int bad   = 0;

    overlay_scope_ctrl dut (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .din     (din),
        .sample  (sample),
        .status  (status),
        .hsync   (hsync),
        .vsync   (vsync),
        .en      (en),
        .color   (color)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic tick();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start_line();
        hsync = 1'b0;
        tick();
        hsync = 1'b1;
    endtask

    task automatic short_lines(input int n);
        repeat (n) begin
            start_line();
            tick();
        end
    endtask

    task automatic do_sample(input logic [7:0] d);
        din = d;
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #7 reset_n = 1'b1;
        run(2);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL rst_color got=%0h want=0", color); end
        total++;
        if (dut.peak !== 7'd0) begin bad++; $display("FAIL rst_peak got=%0d want=0", dut.peak); end
        total++;
        if (dut.wr_ptr !== 5'd0) begin bad++; $display("FAIL rst_wr_ptr got=%0d want=0", dut.wr_ptr); end
        reset_n = 1'b1;
        run(2);
        total++;
        if (dut.state !== FILL) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state, FILL); end
        total++;
        if (dut.hcount !== 13'd2) begin bad++; $display("FAIL rst_hcount got=%0d want=2", dut.hcount); end
    endtask

    task automatic test_commit();
        do_sample(8'h90);
        do_sample(8'h20);
        do_sample(8'h70);
        total++;
        if (dut.peak !== 7'd96) begin bad++; $display("FAIL peak_acc got=%0d want=96", dut.peak); end
        frame();
        total++;
        if (dut.u_ram.mem[0] !== 7'd96) begin bad++; $display("FAIL commit_hist0 got=%0d want=96", dut.u_ram.mem[0]); end
        total++;
        if (dut.peak !== 7'd0) begin bad++; $display("FAIL commit_peak got=%0d want=0", dut.peak); end
        total++;
        if (dut.wr_ptr !== 5'd1) begin bad++; $display("FAIL commit_wr_ptr got=%0d want=1", dut.wr_ptr); end
    endtask

    task automatic test_coincident();
        do_sample(8'h85);
        vsync = 1'b0;
        din = 8'hFF;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        vsync = 1'b1;
        tick();
        total++;
        if (dut.u_ram.mem[1] !== 7'd5) begin bad++; $display("FAIL coinc_hist1 got=%0d want=5", dut.u_ram.mem[1]); end
        total++;
        if (dut.peak !== 7'd127) begin bad++; $display("FAIL coinc_peak got=%0d want=127", dut.peak); end
        total++;
        if (dut.wr_ptr !== 5'd2) begin bad++; $display("FAIL coinc_wr_ptr got=%0d want=2", dut.wr_ptr); end
    endtask

    task automatic test_freeze();
        status = 4'b1001;
        for (int f = 0; f < 3; f++) begin
            do_sample(8'h00);
            frame();
            total++;
            if (dut.peak !== 7'd0) begin bad++; $display("FAIL frz_peak%0d got=%0d want=0", f, dut.peak); end
            total++;
            if (dut.wr_ptr !== 5'd2) begin bad++; $display("FAIL frz_wr_ptr%0d got=%0d want=2", f, dut.wr_ptr); end
        end
        total++;
        if (dut.u_ram.mem[0] !== 7'd96 || dut.u_ram.mem[1] !== 7'd5 || dut.u_ram.mem[2] !== 7'd0) begin
            bad++;
            $display("FAIL frz_hist got=%0d,%0d,%0d want=96,5,0", dut.u_ram.mem[0], dut.u_ram.mem[1], dut.u_ram.mem[2]);
        end
        status = 4'b0001;
    endtask

    task automatic test_display();
        do_sample(8'hA8);
        frame();
        short_lines(439);
        start_line();
        run(704);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL disp_latency got=%0h want=0", color); end
        run(1);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL disp_v440 got=%0h want=0", color); end
        start_line();
        run(704);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL disp_h703 got=%0h want=0", color); end
        run(1);
        total++;
        if (color !== 8'h80) begin bad++; $display("FAIL disp_v441 got=%0h want=80", color); end
        run(63);
        total++;
        if (color !== 8'h80) begin bad++; $display("FAIL disp_h767 got=%0h want=80", color); end
        run(1);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL disp_col1 got=%0h want=0", color); end
        short_lines(600);
        start_line();
        run(705);
        total++;
        if (color !== 8'h80) begin bad++; $display("FAIL disp_v1023 got=%0h want=80", color); end
        en = 1'b0;
        run(1);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL disp_en_off got=%0h want=0", color); end
        en = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            do_sample(8'(128 + k));
            frame();
            if (k == 31) begin
                total++;
                if (dut.state !== FILL) begin bad++; $display("FAIL wrap_fill got=%0d want=%0d", dut.state, FILL); end
            end
            if (k == 32) begin
                total++;
                if (dut.state !== RUN) begin bad++; $display("FAIL wrap_run32 got=%0d want=%0d", dut.state, RUN); end
            end
        end
        total++;
        if (dut.wr_ptr !== 5'd1) begin bad++; $display("FAIL wrap_wr_ptr got=%0d want=1", dut.wr_ptr); end
        total++;
        if (dut.state !== RUN) begin bad++; $display("FAIL wrap_state got=%0d want=%0d", dut.state, RUN); end
        total++;
        if (dut.u_ram.mem[0] !== 7'd33 || dut.u_ram.mem[1] !== 7'd2) begin
            bad++;
            $display("FAIL wrap_hist got=%0d,%0d want=33,2", dut.u_ram.mem[0], dut.u_ram.mem[1]);
        end
        short_lines(477);
        start_line();
        run(2689);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL wrap_col31_v478 got=%0h want=0", color); end
        start_line();
        run(2689);
        total++;
        if (color !== 8'h80) begin bad++; $display("FAIL wrap_col31_v479 got=%0h want=80", color); end
        run(64);
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL wrap_col32 got=%0h want=0", color); end
    endtask

    task automatic test_reset_mid();
        do_sample(8'hFF);
        start_line();
        run(2689);
        total++;
        if (color !== 8'h80) begin bad++; $display("FAIL mid_lit got=%0h want=80", color); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (color !== 8'h00) begin bad++; $display("FAIL mid_async_color got=%0h want=0", color); end
        total++;
        if (dut.peak !== 7'd0) begin bad++; $display("FAIL mid_peak got=%0d want=0", dut.peak); end
        repeat (2) @(posedge clk_vid);
        #3 reset_n = 1'b1;
        tick();
        total++;
        if (dut.wr_ptr !== 5'd0 || dut.state !== FILL) begin
            bad++;
            $display("FAIL mid_ptr_state got=%0d,%0d want=0,%0d", dut.wr_ptr, dut.state, FILL);
        end
        short_lines(1100);
        start_line();
        for (int k = 1; k <= 2753; k++) begin
            tick();
            if (k >= 705 && (k - 705) % 64 == 0) begin
                total++;
                if (color !== 8'h00) begin bad++; $display("FAIL mid_dark_col%0d got=%0h want=0", (k - 705) / 64, color); end
            end
        end
        do_sample(8'h90);
        frame();
        total++;
        if (dut.u_ram.mem[0] !== 7'd16) begin bad++; $display("FAIL mid_first_commit got=%0d want=16", dut.u_ram.mem[0]); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_coincident();
        test_freeze();
        test_display();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
